sr_bank_arb: RTL and testbench

Arbiter and sequencer for a bank of N clocked `sr` flip-flops shared by two requesters. Each requester asks for a SET, CLEAR or TOGGLE of one bank bit. The block grants the requesters round-robin and drives exactly one bit's `s` or `r` for one clock. It then holds the whole bank quiet for one settle cycle and acknowledges. By construction the forbidden `s=r=1` input never reaches any flip-flop. It sits between control logic and the `sr` bank, whose `q` outputs feed back into it.

---
 rtl/sr_pkg.sv | 34 +++
 rtl/rr_arb2.sv | 22 ++
 rtl/sr_bank_arb.sv | 109 ++++++++++
 tb/tb_sr_bank_arb.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sr_pkg.sv
// Shared op codes, FSM encodings and the op-to-drive decode for the sr bank arbiter.
package sr_pkg;

  localparam logic [1:0] SR_NOP = 2'b00;
  localparam logic [1:0] SR_SET = 2'b01;
  localparam logic [1:0] SR_CLR = 2'b10;
  localparam logic [1:0] SR_TGL = 2'b11;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DRIVE  = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;

  typedef struct packed {
    logic s;
    logic r;
  } drv_t;

  // s and r are mutually exclusive by construction; TOGGLE inverts the sampled q.
  function automatic drv_t op_decode(input logic [1:0] op, input logic q);
    drv_t d;
    d = '0;
    case (op)
      SR_SET:  d.s = 1'b1;
      SR_CLR:  d.r = 1'b1;
      SR_TGL:  begin
        d.s = ~q;
        d.r = q;
      end
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves past whoever was last granted.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic r_prio;  // 0: req0 wins a tie, 1: req1 wins a tie

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = r_prio ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_prio <= 1'b0;
    else if (advance && |gnt)  r_prio <= gnt[0];
  end

endmodule

// File: rtl/sr_bank_arb.sv
// Serialises SET/CLR/TOGGLE requests from two masters onto a bank of sr flops:
// one drive cycle, one quiet settle cycle with ack, then back to idle.
module sr_bank_arb
  import sr_pkg::*;
#(
  parameter  int IDXW = 3,
  localparam int N    = 1 << IDXW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0,
  input  logic            req1,
  input  logic [1:0]      op0,
  input  logic [1:0]      op1,
  input  logic [IDXW-1:0] idx0,
  input  logic [IDXW-1:0] idx1,
  output logic            ack0,
  output logic            ack1,
  input  logic [N-1:0]    q_vec,
  output logic [N-1:0]    s_vec,
  output logic [N-1:0]    r_vec,
  output logic            busy
);

  logic [1:0]      r_state;
  logic [1:0]      r_gnt;
  logic [N-1:0]    r_s;
  logic [N-1:0]    r_r;
  logic            r_ack0;
  logic            r_ack1;
  logic            r_busy;

  logic            w_any;
  logic            w_advance;
  logic [1:0]      w_gnt;
  logic [1:0]      w_op;
  logic [IDXW-1:0] w_idx;
  logic [N-1:0]    w_onehot;
  drv_t            w_drv;

  assign w_any     = req0 | req1;
  assign w_advance = (r_state == ST_IDLE) && w_any;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({req1, req0}),
    .advance (w_advance),
    .gnt     (w_gnt)
  );

  // Mux the winner's op/idx and decode against q as sampled at the grant edge.
  assign w_op     = w_gnt[1] ? op1  : op0;
  assign w_idx    = w_gnt[1] ? idx1 : idx0;
  assign w_onehot = {{(N-1){1'b0}}, 1'b1} << w_idx;
  assign w_drv    = op_decode(w_op, q_vec[w_idx]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_s     <= '0;
      r_r     <= '0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_gnt   <= w_gnt;
            r_s     <= w_drv.s ? w_onehot : '0;
            r_r     <= w_drv.r ? w_onehot : '0;
            r_busy  <= 1'b1;
            r_state <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          r_s     <= '0;
          r_r     <= '0;
          r_ack0  <= r_gnt[0];
          r_ack1  <= r_gnt[1];
          r_state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_s     <= '0;
          r_r     <= '0;
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign s_vec = r_s;
  assign r_vec = r_r;
  assign ack0  = r_ack0;
  assign ack1  = r_ack1;
  assign busy  = r_busy;

endmodule

// File: tb/tb_sr_bank_arb.sv
// Bench for sr_bank_arb with an sr flop bank attached and a transaction-level reference model.
module tb_sr_bank_arb;
  import sr_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [1:0] op0 = 2'b00, op1 = 2'b00;
  logic [2:0] idx0 = 3'd0, idx1 = 3'd0;
  logic       ack0, ack1, busy;
  logic [7:0] s_vec, r_vec;
  logic [7:0] q_bank = '0;

  always #5 clk = ~clk;

  sr_bank_arb #(.IDXW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1), .idx0(idx0), .idx1(idx1),
    .ack0(ack0), .ack1(ack1), .q_vec(q_bank), .s_vec(s_vec), .r_vec(r_vec), .busy(busy)
  );

  // The sr bank itself: s sets, r clears, neither holds.
  always @(posedge clk)
    for (int i = 0; i < 8; i++)
      if (s_vec[i])      q_bank[i] <= 1'b1;
      else if (r_vec[i]) q_bank[i] <= 1'b0;

  int n_chk = 0, n_pass = 0, viol = 0, cyc = 0;

  always @(negedge clk)
    if (((s_vec & r_vec) != 0) || ($countones(s_vec | r_vec) > 1) || (ack0 && ack1))
      viol++;

  // Reference model: phase of the current transaction (0 idle, 1 driven, 2 acked),
  // who holds it, who won last, and the bank contents at operation granularity.
  int         ph = 0, g = 0, last = 1;
  logic [7:0] mq = '0, mq_prev = '0;
  int         gq[$];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
  endtask

  task automatic model_reset();
    if (ph == 1) mq = mq_prev;
    ph   = 0;
    last = 1;
  endtask

  task automatic step(input string nm);
    logic [7:0] es, er;
    logic [1:0] o;
    logic [2:0] ix;
    es = '0; er = '0;
    if (ph == 0) begin
      if (req0 || req1) begin
        g    = (req0 && req1) ? 1 - last : (req0 ? 0 : 1);
        last = g;
        o    = g ? op1 : op0;
        ix   = g ? idx1 : idx0;
        mq_prev = mq;
        if (o == SR_SET || (o == SR_TGL && !mq[ix])) begin
          es[ix] = 1'b1; mq[ix] = 1'b1;
        end else if (o == SR_CLR || o == SR_TGL) begin
          er[ix] = 1'b1; mq[ix] = 1'b0;
        end
        ph = 1;
      end
    end else if (ph == 1) ph = 2;
    else ph = 0;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check({nm, "_out"}, {13'd0, busy, ack1, ack0, s_vec, r_vec},
          {13'd0, ph != 0, ph == 2 && g == 1, ph == 2 && g == 0, es, er});
    if (ph != 1) check({nm, "_q"}, {24'd0, q_bank}, {24'd0, mq});
  endtask

  typedef struct {
    logic [1:0] op;
    logic [2:0] idx;
    logic [7:0] es;
    logic [7:0] er;
    logic       eq;
  } vec_t;
  vec_t tbl[8];

  initial begin
    int t0, t1, nb, na;
    tbl[0] = '{SR_SET, 3'd3, 8'h08, 8'h00, 1'b1};
    tbl[1] = '{SR_CLR, 3'd3, 8'h00, 8'h08, 1'b0};
    tbl[2] = '{SR_TGL, 3'd5, 8'h20, 8'h00, 1'b1};
    tbl[3] = '{SR_TGL, 3'd5, 8'h00, 8'h20, 1'b0};
    tbl[4] = '{SR_NOP, 3'd1, 8'h00, 8'h00, 1'b0};
    tbl[5] = '{SR_SET, 3'd7, 8'h80, 8'h00, 1'b1};
    tbl[6] = '{SR_TGL, 3'd7, 8'h00, 8'h80, 1'b0};
    tbl[7] = '{SR_CLR, 3'd0, 8'h00, 8'h01, 1'b0};

    repeat (2) @(negedge clk);
    check("reset", {13'd0, busy, ack1, ack0, s_vec, r_vec}, 32'd0);
    rst_n = 1'b1;

    // Single-requester vectors, one operation per row, bank state chained row to row.
    for (int i = 0; i < 8; i++) begin
      op0 = tbl[i].op; idx0 = tbl[i].idx; req0 = 1'b1;
      step("tbl");
      check($sformatf("tbl%0d_drive", i), {16'd0, s_vec, r_vec}, {16'd0, tbl[i].es, tbl[i].er});
      step("tbl");
      check($sformatf("tbl%0d_ack", i), {31'd0, ack0}, 32'd1);
      req0 = 1'b0;
      step("tbl");
      check($sformatf("tbl%0d_q", i), {31'd0, q_bank[tbl[i].idx]}, {31'd0, tbl[i].eq});
    end

    rst_n = 1'b0;
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;

    // Simultaneous requests on the same bit: req0 CLR first, then req1 SET.
    req0 = 1'b1; op0 = SR_CLR; idx0 = 3'd2;
    req1 = 1'b1; op1 = SR_SET; idx1 = 3'd2;
    step("sim");
    check("sim_first_r", {16'd0, s_vec, r_vec}, {16'd0, 8'h00, 8'h04});
    step("sim");
    t0 = cyc;
    check("sim_ack0", {31'd0, ack0}, 32'd1);
    req0 = 1'b0;
    step("sim");
    step("sim");
    check("sim_second_s", {16'd0, s_vec, r_vec}, {16'd0, 8'h04, 8'h00});
    step("sim");
    t1 = cyc;
    check("sim_ack1", {31'd0, ack1}, 32'd1);
    req1 = 1'b0;
    check("sim_ack_gap", t1 - t0, 32'd3);
    step("sim");
    check("sim_q2", {31'd0, q_bank[2]}, 32'd1);

    // Fairness: both held, a fresh op presented at each ack.
    gq.delete();
    req0 = 1'b1; op0 = SR_SET; idx0 = 3'd6;
    req1 = 1'b1; op1 = SR_TGL; idx1 = 3'd6;
    for (int k = 0; k < 60 && gq.size() < 6; k++) begin
      step("fair");
      if (ph == 2) begin
        gq.push_back(g);
        if (g == 0) begin op0 = 2'($urandom_range(1, 3)); idx0 = 3'($urandom); end
        else        begin op1 = 2'($urandom_range(1, 3)); idx1 = 3'($urandom); end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    check("fair_count", gq.size(), 32'd6);
    for (int k = 0; k < 6 && k < gq.size(); k++)
      check($sformatf("fair_gnt%0d", k), gq[k], k % 2);
    step("fair");

    // NOP from req1: full sequence, nothing driven.
    req1 = 1'b1; op1 = SR_NOP; idx1 = 3'd4;
    nb = 0; na = 0;
    for (int k = 0; k < 5; k++) begin
      step("nop");
      if (busy) nb++;
      if (ack1) begin na++; req1 = 1'b0; end
    end
    check("nop_busy_cycles", nb, 32'd2);
    check("nop_acks", na, 32'd1);

    // Reset during DRIVE, after a req0 grant, so the pointer would otherwise favour req1.
    req0 = 1'b1; op0 = SR_SET; idx0 = 3'd4;
    step("mid");
    check("mid_drive", {24'd0, s_vec}, 32'h10);
    #2 rst_n = 1'b0;
    #1 check("mid_rst_async", {13'd0, busy, ack1, ack0, s_vec, r_vec}, 32'd0);
    model_reset();
    req0 = 1'b0;
    #1 rst_n = 1'b1;
    step("post_rst");
    step("post_rst");
    check("post_rst_q4", {31'd0, q_bank[4]}, 32'd0);
    req0 = 1'b1; op0 = SR_SET; idx0 = 3'd1;
    req1 = 1'b1; op1 = SR_SET; idx1 = 3'd2;
    step("rst_rr");
    check("rst_rr_gnt0", {24'd0, s_vec}, 32'h02);
    step("rst_rr");
    req0 = 1'b0;
    step("rst_rr");
    step("rst_rr");
    step("rst_rr");
    req1 = 1'b0;
    step("rst_rr");

    // Randomised traffic against the model.
    for (int k = 0; k < 400; k++) begin
      step("rand");
      if (ph == 2) begin
        if (g == 0) begin
          if ($urandom_range(0, 1) == 0) req0 = 1'b0;
          else begin op0 = 2'($urandom); idx0 = 3'($urandom); end
        end else begin
          if ($urandom_range(0, 1) == 0) req1 = 1'b0;
          else begin op1 = 2'($urandom); idx1 = 3'($urandom); end
        end
      end
      if (!req0 && $urandom_range(0, 2) == 0) begin
        req0 = 1'b1; op0 = 2'($urandom); idx0 = 3'($urandom);
      end
      if (!req1 && $urandom_range(0, 2) == 0) begin
        req1 = 1'b1; op1 = 2'($urandom); idx1 = 3'($urandom);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) step("drain");

    check("invariants", viol, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
